// File: rtl/comm_deframer.sv
// comm_deframer: receive-side deframer for the analog inter-board link.
// Aligns the data and envelope ADC lanes, slices them and recovers parity-checked words.
module comm_deframer #(
    parameter int SYM_CYCLES = 8,
    parameter int THRESH     = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  ad1,
    input  logic [7:0]  ad2,
    input  logic [3:0]  ad1_delay,
    input  logic [3:0]  ad2_delay,
    input  logic [3:0]  ad_valid_delay,
    output logic        valid_o,
    output logic [31:0] data_o,
    input  logic        ack_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int            PW      = $clog2(SYM_CYCLES);
    localparam logic [PW-1:0] PH_LAST = PW'(SYM_CYCLES - 1);
    localparam logic [7:0]    THR     = 8'(THRESH);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SAMPLE,
        CHECK,
        WAIT_LOW
    } state_t;

    state_t        state;
    logic [7:0]    line1 [16];
    logic [7:0]    line2 [16];
    logic          b1;
    logic          b2;
    logic          b2_q;
    logic          sample_now;
    logic [3:0]    align_cnt;
    logic [PW-1:0] phase;
    logic [5:0]    bit_cnt;
    logic [32:0]   shreg;

    // Entry 0 is the input register; entry d adds d cycles of skew.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                line1[i] <= '0;
                line2[i] <= '0;
            end
        end else begin
            line1[0] <= ad1;
            line2[0] <= ad2;
            for (int i = 1; i < 16; i++) begin
                line1[i] <= line1[i-1];
                line2[i] <= line2[i-1];
            end
        end
    end

    assign b1 = (line1[ad1_delay] >= THR);
    assign b2 = (line2[ad2_delay] >= THR);

    assign sample_now = ((state == ALIGN) && (align_cnt == '0))
                     || ((state == SAMPLE) && (phase == '0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            b2_q         <= 1'b0;
            align_cnt    <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            b2_q         <= b2;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            if (valid_o && ack_o) begin
                valid_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (b2 && !b2_q) begin
                        align_cnt <= ad_valid_delay;
                        shreg     <= '0;
                        bit_cnt   <= '0;
                        state     <= ALIGN;
                    end
                end
                ALIGN, SAMPLE: begin
                    if (sample_now) begin
                        shreg   <= {shreg[31:0], b1};
                        phase   <= PH_LAST;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (!b2) begin
                            frame_err_o <= 1'b1;
                            state       <= IDLE;
                        end else if (bit_cnt == 6'd32) begin
                            state <= CHECK;
                        end else begin
                            state <= SAMPLE;
                        end
                    end else if (state == ALIGN) begin
                        align_cnt <= align_cnt - 4'd1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                CHECK: begin
                    // A slot freed by this cycle's ack can take the new word.
                    if (^shreg) begin
                        parity_err_o <= 1'b1;
                    end else if (!valid_o || ack_o) begin
                        valid_o <= 1'b1;
                        data_o  <= shreg[32:1];
                    end else if (drop_cnt_o != 8'hFF) begin
                        drop_cnt_o <= drop_cnt_o + 8'd1;
                    end
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!b2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_deframer.sv
// tb_comm_deframer: directed and randomized frames against a timing-level
// reference model of sampling points, frame outcome and the output slot.
module tb_comm_deframer;

    localparam int S = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  ad1 = 8'd20;
    logic [7:0]  ad2 = 8'd20;
    logic [3:0]  ad1_delay = '0;
    logic [3:0]  ad2_delay = '0;
    logic [3:0]  ad_valid_delay = '0;
    logic        ack_o = 1'b0;
    logic        valid_o;
    logic [31:0] data_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic [7:0]  drop_cnt_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mv = 1'b0;
    logic [31:0] md = '0;
    int          mdrop = 0;
    int          del_cyc = -1;
    int          pe_cyc = -1;
    int          fe_cyc = -1;
    logic [31:0] del_word = '0;
    bit          fixed_lv = 1'b1;
    int          ack_mode = 1;

    comm_deframer #(
        .SYM_CYCLES(S),
        .THRESH(128)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ad1(ad1),
        .ad2(ad2),
        .ad1_delay(ad1_delay),
        .ad2_delay(ad2_delay),
        .ad_valid_delay(ad_valid_delay),
        .valid_o(valid_o),
        .data_o(data_o),
        .ack_o(ack_o),
        .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h at cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    // Sample outputs mid-cycle, advance the slot model, then drive ack.
    task automatic tick();
        bit freed;
        @(negedge CLK);
        cyc++;
        freed = mv && ack_o;
        if (RST) begin
            mv      = 1'b0;
            md      = '0;
            mdrop   = 0;
            del_cyc = -1;
            pe_cyc  = -1;
            fe_cyc  = -1;
        end else if (cyc == del_cyc) begin
            if (!mv || freed) begin
                mv = 1'b1;
                md = del_word;
            end else if (mdrop < 255) begin
                mdrop++;
            end
        end else if (freed) begin
            mv = 1'b0;
        end
        chk("valid_o", 32'(valid_o), 32'(mv));
        chk("parity_err_o", 32'(parity_err_o), 32'(cyc == pe_cyc));
        chk("frame_err_o", 32'(frame_err_o), 32'(cyc == fe_cyc));
        chk("drop_cnt_o", 32'(drop_cnt_o), 32'(mdrop));
        if (mv) chk("data_o", data_o, md);
        if (RST) chk("data_o_rst", data_o, 32'h0);
        if (ack_mode == 2) ack_o = 1'($urandom_range(1, 0));
        else ack_o = (ack_mode == 1);
    endtask

    task automatic drive_lanes(input bit env, input bit bv);
        if (fixed_lv) begin
            ad2 = env ? 8'd200 : 8'd20;
            ad1 = bv ? 8'd200 : 8'd20;
        end else begin
            ad2 = env ? 8'($urandom_range(255, 128)) : 8'($urandom_range(127, 0));
            ad1 = bv ? 8'($urandom_range(255, 128)) : 8'($urandom_range(127, 0));
        end
    endtask

    function automatic int env_for(input int skew);
        return 33 * S + skew + int'(ad_valid_delay) + 2;
    endfunction

    // Predict outcome from link timing, then transmit the frame cycle by cycle.
    task automatic run_frame(input logic [31:0] data, input bit pbit,
                             input int skew, input int env_len,
                             input int gap, input int rst_sym);
        logic [32:0] fb;
        logic [32:0] w;
        int t0, sc, rel, sym, total, rst_at;
        bit done, bv, cut;
        fb      = {data, pbit};
        t0      = cyc + 1;
        del_cyc = -1;
        pe_cyc  = -1;
        fe_cyc  = -1;
        w       = '0;
        done    = 1'b0;
        sc      = 0;
        for (int k = 0; k < 33 && !done; k++) begin
            sc = t0 + int'(ad2_delay) + int'(ad_valid_delay) + 2 + k * S;
            if (sc - 1 - int'(ad2_delay) - t0 >= env_len) begin
                fe_cyc = sc + 1;
                done   = 1'b1;
            end else begin
                rel = sc - 1 - int'(ad1_delay) - t0 - skew;
                sym = (rel < 0) ? -1 : rel / S;
                bv  = (sym >= 0 && sym < 33) ? fb[32-sym] : 1'b0;
                w   = {w[31:0], bv};
            end
        end
        if (!done) begin
            if (^w) begin
                pe_cyc = sc + 2;
            end else begin
                del_cyc  = sc + 2;
                del_word = w[32:1];
            end
        end
        total  = ((env_len > skew + 33 * S) ? env_len : skew + 33 * S) + gap;
        rst_at = (rst_sym >= 0) ? skew + rst_sym * S : -1;
        cut    = 1'b0;
        for (int i = 0; i < total; i++) begin
            tick();
            if (i == rst_at) cut = 1'b1;
            RST = (i == rst_at);
            rel = i - skew;
            bv  = (!cut && rel >= 0 && rel < 33 * S) ? fb[32-rel/S] : 1'b0;
            drive_lanes(!cut && i < env_len, bv);
        end
    endtask

    initial begin
        logic [31:0] w;
        int off, base, lo, hi;

        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        repeat (4) tick();

        fixed_lv       = 1'b1;
        ack_mode       = 1;
        ad1_delay      = 4'd0;
        ad2_delay      = 4'd0;
        ad_valid_delay = 4'd4;
        run_frame(32'hDEADBEEF, 1'b0, 0, env_for(0), 20, -1);
        run_frame(32'hDEADBEEF, 1'b1, 0, env_for(0), 20, -1);
        chk("parity_fail_drop", 32'(drop_cnt_o), 32'h0);

        run_frame(32'h12345678, 1'b1, 0, 11 * S, 20, -1);
        run_frame(32'h0000000F, 1'b0, 0, env_for(0), 20, -1);

        ad2_delay = 4'd5;
        run_frame(32'hCAFEF00D, 1'b0, 5, env_for(5), 20, -1);
        // Envelope not delayed: sampling lands one symbol early.
        ad2_delay      = 4'd0;
        ad_valid_delay = 4'd0;
        run_frame(32'hCAFEF00D, 1'b0, 5, env_for(5), 20, -1);

        fixed_lv = 1'b0;
        ack_mode = 2;
        for (int n = 0; n < 10; n++) begin
            ad1_delay      = 4'($urandom_range(15, 0));
            off            = $urandom_range(6, 1);
            lo             = $urandom_range(8, 0);
            base           = off - 1 + int'(ad1_delay) + lo;
            hi             = (base > 15) ? 15 : base;
            ad2_delay      = 4'($urandom_range(hi, (base > 15) ? base - 15 : 0));
            ad_valid_delay = 4'(base - int'(ad2_delay));
            w              = $urandom;
            run_frame(w, 1'($urandom_range(1, 0)), lo, env_for(lo), 20, -1);
        end

        ack_mode = 1;
        repeat (5) tick();
        ack_mode       = 0;
        ad1_delay      = 4'd0;
        ad2_delay      = 4'd0;
        ad_valid_delay = 4'd4;
        run_frame(32'hA5A5A5A5, 1'b0, 0, env_for(0), 4, -1);
        run_frame(32'h5A5A5A5A, 1'b0, 0, env_for(0), 4, -1);
        chk("bp_hold", data_o, 32'hA5A5A5A5);
        chk("bp_drop1", 32'(drop_cnt_o), 32'd1);
        for (int n = 0; n < 255; n++) begin
            w = $urandom;
            run_frame(w, ^w, 0, env_for(0), 4, -1);
        end
        chk("bp_sat", 32'(drop_cnt_o), 32'd255);
        chk("bp_hold_sat", data_o, 32'hA5A5A5A5);
        chk("bp_valid_sat", 32'(valid_o), 32'd1);

        w = $urandom;
        run_frame(w, ^w, 0, env_for(0), 20, 20);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        ack_mode = 1;
        run_frame(32'h00000001, 1'b1, 0, env_for(0), 20, -1);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
